// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: FSM, ALU decode, NZCV flags, cond gating.
// Ports: clk/reset_n, instr fields (Op, Funct, Rd, Cond), ALUFlags, MemReady in;
//        write enables, mux selects, ALUControl, ImmSrc, RegSrc, State, Flags out.
module multicycle_controller #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_w;
    logic       alu_op;
    logic       is_cmp;
    logic       flag_w1;
    logic       flag_w0;
    logic       cond_ex;
    logic       pcs;
    logic       n_f, z_f, c_f, v_f;

    assign is_cmp = (Funct[4:1] == 4'b1010);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = MemReady;
                next_pc   = MemReady;
                state_d   = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            // compares only update flags, never the register file
            S_ALUWB: reg_w = ~is_cmp;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b1010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    // logic ops leave C and V alone
    assign flag_w1 = alu_op & Funct[0];
    assign flag_w0 = flag_w1 & ~ALUControl[1];

    assign {n_f, z_f, c_f, v_f} = Flags;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= FLAG_RESET;
        end else begin
            if (flag_w1 & cond_ex) Flags[3:2] <= ALUFlags[3:2];
            if (flag_w0 & cond_ex) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs = branch | (reg_w & (Rd == 4'd15));

    // enables are forced low while reset is held, even in FETCH
    assign PCWrite  = reset_n & (next_pc | (pcs & cond_ex));
    assign RegWrite = reset_n & reg_w & cond_ex;
    assign MemWrite = reset_n & mem_w & cond_ex;
    assign IRWrite  = reset_n & ir_w;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations queued
// per instruction, then popped and compared against the DUT each cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, RegWrite, MemWrite, IRWrite;
    logic       AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State, Flags;

    int checks = 0;
    int errors = 0;
    string cur = "init";

    typedef struct {
        logic       mr;
        logic [3:0] st;
        logic [3:0] en;
        logic [3:0] fl;
    } ent_t;

    ent_t sb[$];

    multicycle_controller #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .State(State), .Flags(Flags)
    );

    always #5 clk = ~clk;

    // {AdrSrc, ResultSrc} expected in each state
    function automatic logic [2:0] sel_of(input logic [3:0] st);
        case (st)
            4'd0, 4'd1, 4'd9: sel_of = 3'b010;
            4'd3, 4'd5:       sel_of = 3'b100;
            4'd4:             sel_of = 3'b001;
            default:          sel_of = 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [14:0] obs,
                         input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic mr, input logic [3:0] st,
                        input logic [3:0] en, input logic [3:0] fl);
        ent_t e;
        e.mr = mr; e.st = st; e.en = en; e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic drain();
        ent_t e;
        int idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MemReady = e.mr;
            #1;
            check($sformatf("%s.c%0d", cur, idx),
                  {State, PCWrite, RegWrite, MemWrite, IRWrite,
                   AdrSrc, ResultSrc, Flags},
                  {e.st, e.en, sel_of(e.st), e.fl});
            idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input string tag, input logic [1:0] op,
                         input logic [5:0] fn, input logic [3:0] rd,
                         input logic [3:0] cnd, input logic [3:0] af);
        cur = tag;
        Op = op; Funct = fn; Rd = rd; Cond = cnd; ALUFlags = af;
    endtask

    initial begin
        reset_n = 1'b0;
        MemReady = 1'b1;
        instr("init", 2'b00, 6'b0, 4'd0, 4'hE, 4'h0);
        #2;
        check("reset", {3'b0, State, PCWrite, RegWrite, MemWrite, IRWrite, Flags},
              {3'b0, 4'd0, 4'b0000, 4'b0000});
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ADD R1,R2,R3 : S=0 so ALUFlags ignored
        instr("add", 2'b00, 6'b001000, 4'd1, 4'hE, 4'b1111);
        push(1, 0, 4'b1001, 4'h0); push(1, 1, 4'b0000, 4'h0);
        push(1, 6, 4'b0000, 4'h0); push(1, 8, 4'b0100, 4'h0);
        drain();

        instr("subs", 2'b00, 6'b000101, 4'd2, 4'hE, 4'b0100);
        push(1, 0, 4'b1001, 4'h0); push(1, 1, 4'b0000, 4'h0);
        push(1, 6, 4'b0000, 4'h0); push(1, 8, 4'b0100, 4'b0100);
        drain();

        instr("beq_taken", 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0);
        #1;
        check("regsrc_b", {13'b0, RegSrc}, {13'b0, 2'b01});
        push(1, 0, 4'b1001, 4'b0100); push(1, 1, 4'b0000, 4'b0100);
        push(1, 9, 4'b1000, 4'b0100);
        drain();

        // CMP: flags all four from ALU, no register write
        instr("cmp", 2'b00, 6'b010101, 4'd0, 4'hE, 4'b0010);
        push(1, 0, 4'b1001, 4'b0100); push(1, 1, 4'b0000, 4'b0100);
        push(1, 6, 4'b0000, 4'b0100); push(1, 8, 4'b0000, 4'b0010);
        drain();

        instr("beq_not", 2'b10, 6'b100000, 4'd0, 4'h0, 4'h0);
        push(1, 0, 4'b1001, 4'b0010); push(1, 1, 4'b0000, 4'b0010);
        push(1, 9, 4'b0000, 4'b0010);
        drain();

        // ANDS: only N,Z update
        instr("ands", 2'b00, 6'b000001, 4'd6, 4'hE, 4'b1111);
        push(1, 0, 4'b1001, 4'b0010); push(1, 1, 4'b0000, 4'b0010);
        push(1, 6, 4'b0000, 4'b0010); push(1, 8, 4'b0100, 4'b1110);
        drain();

        instr("ldr_stall", 2'b01, 6'b011001, 4'd3, 4'hE, 4'h0);
        #1;
        check("ldr_src", {11'b0, RegSrc, ImmSrc}, {11'b0, 2'b10, 2'b01});
        push(0, 0, 4'b0000, 4'hE); push(0, 0, 4'b0000, 4'hE);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 2, 4'b0000, 4'hE); push(0, 3, 4'b0000, 4'hE);
        push(1, 3, 4'b0000, 4'hE); push(1, 4, 4'b0100, 4'hE);
        drain();

        // NE fails with Z=1
        instr("str_ne", 2'b01, 6'b011000, 4'd4, 4'h1, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 2, 4'b0000, 4'hE); push(0, 5, 4'b0000, 4'hE);
        push(1, 5, 4'b0000, 4'hE);
        drain();

        instr("str_al", 2'b01, 6'b011000, 4'd4, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 2, 4'b0000, 4'hE); push(0, 5, 4'b0010, 4'hE);
        push(1, 5, 4'b0010, 4'hE);
        drain();

        instr("add_pc", 2'b00, 6'b001000, 4'd15, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 6, 4'b0000, 4'hE); push(1, 8, 4'b1100, 4'hE);
        drain();

        instr("addi", 2'b00, 6'b101000, 4'd5, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 7, 4'b0000, 4'hE); push(1, 8, 4'b0100, 4'hE);
        drain();

        instr("add_ne", 2'b00, 6'b001000, 4'd7, 4'h1, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 6, 4'b0000, 4'hE); push(1, 8, 4'b0000, 4'hE);
        drain();

        instr("op11", 2'b11, 6'b000000, 4'd0, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        drain();

        instr("ldr_rst", 2'b01, 6'b011001, 4'd3, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'hE); push(1, 1, 4'b0000, 4'hE);
        push(1, 2, 4'b0000, 4'hE);
        drain();
        MemReady = 1'b0;
        #1;
        check("in_memrd", {3'b0, State, PCWrite, RegWrite, MemWrite, IRWrite, Flags},
              {3'b0, 4'd3, 4'b0000, 4'hE});
        MemReady = 1'b1;
        reset_n = 1'b0;
        #1;
        check("async_rst", {3'b0, State, PCWrite, RegWrite, MemWrite, IRWrite, Flags},
              {3'b0, 4'd0, 4'b0000, 4'h0});
        @(posedge clk); #1;
        check("rst_hold", {3'b0, State, PCWrite, RegWrite, MemWrite, IRWrite, Flags},
              {3'b0, 4'd0, 4'b0000, 4'h0});
        reset_n = 1'b1;

        instr("bal_after", 2'b10, 6'b100000, 4'd0, 4'hE, 4'h0);
        push(1, 0, 4'b1001, 4'h0); push(1, 1, 4'b0000, 4'h0);
        push(1, 9, 4'b1000, 4'h0); push(1, 0, 4'b1001, 4'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
